// File: rtl/adc_parallel_ctrl_if.sv
// Parallel ADC bus interface: chip select, read/write select, bidirectional data
// (split into input, drive value and drive enable), reset and data-ready.
//   master : controller side (drives cs_n, r_n_w, o_rest_n, adc_data_o/oe)
//   slave  : ADC side (drives drdy_n, adc_data_i)
interface adc_parallel_ctrl_if #(
  parameter int unsigned DATA_W = 16
);
  logic              drdy_n;
  logic [DATA_W-1:0] adc_data_i;
  logic [DATA_W-1:0] adc_data_o;
  logic              adc_data_oe;
  logic              cs_n;
  logic              r_n_w;
  logic              o_rest_n;

  modport master (
    input  drdy_n,
    input  adc_data_i,
    output adc_data_o,
    output adc_data_oe,
    output cs_n,
    output r_n_w,
    output o_rest_n
  );

  modport slave (
    output drdy_n,
    output adc_data_i,
    input  adc_data_o,
    input  adc_data_oe,
    input  cs_n,
    input  r_n_w,
    input  o_rest_n
  );
endinterface

// File: rtl/adc_parallel_ctrl.sv
// Parallel ADC controller. On command it pulses the ADC reset, writes NUM_REGS
// address/value pairs from cfg_table over the parallel bus, waits to settle and
// then captures one sample per drdy_n falling edge into a single-entry output
// register with a ready/valid handshake and a sticky overflow flag.
// Ports:
//   mclk, i_rest_n  : clock, asynchronous active-low reset
//   command         : run request level; dropping it aborts back to idle
//   cfg_table       : pair k at [(2k+2)*DATA_W-1 : 2k*DATA_W], address in upper half
//   adc             : ADC bus (master modport)
//   dout/dout_valid/dout_ready : captured sample stream
//   overflow        : sticky, set when a sample arrives while dout is held
//   busy, cfg_done  : status (not idle / configured and running)
module adc_parallel_ctrl #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned NUM_REGS     = 2,
  parameter int unsigned CS_LOW_CYC   = 8,
  parameter int unsigned CS_HIGH_CYC  = 8,
  parameter int unsigned RST_LOW_CYC  = 2,
  parameter int unsigned RST_HIGH_CYC = 3,
  parameter int unsigned SETTLE_CYC   = 6
) (
  input  logic                         mclk,
  input  logic                         i_rest_n,
  input  logic                         command,
  input  logic [NUM_REGS*2*DATA_W-1:0] cfg_table,
  adc_parallel_ctrl_if.master          adc,
  output logic [DATA_W-1:0]            dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         overflow,
  output logic                         busy,
  output logic                         cfg_done
);

  localparam int unsigned NumWords = 2 * NUM_REGS;
  localparam int unsigned IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned CntW     = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRstLo,
    StRstHi,
    StWrAssert,
    StWrGap,
    StSettle,
    StRun
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [2:0]        sync_q, sync_d;
  logic              cs_n_q, cs_n_d;
  logic              r_n_w_q, r_n_w_d;
  logic              o_rest_n_q, o_rest_n_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] data_o_q, data_o_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              cfg_done_q, cfg_done_d;

  logic              cyc_last;
  logic              drdy_fall;
  logic              capture;
  logic [DATA_W-1:0] words [NumWords];

  // Word 2k is the address (upper half of pair k), word 2k+1 its value.
  for (genvar p = 0; p < NUM_REGS; p++) begin : g_words
    assign words[2*p]   = cfg_table[(2*p+1)*DATA_W +: DATA_W];
    assign words[2*p+1] = cfg_table[(2*p)*DATA_W +: DATA_W];
  end

  // Last cycle of the current timed state.
  always_comb begin
    cyc_last = 1'b0;
    unique case (state_q)
      StRstLo:    cyc_last = (cnt_q == CntW'(RST_LOW_CYC - 1));
      StRstHi:    cyc_last = (cnt_q == CntW'(RST_HIGH_CYC - 1));
      StWrAssert: cyc_last = (cnt_q == CntW'(CS_LOW_CYC - 1));
      StWrGap:    cyc_last = (cnt_q == CntW'(CS_HIGH_CYC - 1));
      StSettle:   cyc_last = (cnt_q == CntW'(SETTLE_CYC - 1));
      default:    cyc_last = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (command) state_d = StRstLo;
      end
      StRstLo:    if (cyc_last) state_d = StRstHi;
      StRstHi:    if (cyc_last) state_d = StWrAssert;
      StWrAssert: if (cyc_last) state_d = StWrGap;
      StWrGap: begin
        if (cyc_last) begin
          if (idx_q == IdxW'(NumWords - 1)) begin
            state_d = StSettle;
          end else begin
            state_d = StWrAssert;
            idx_d   = idx_q + IdxW'(1);
          end
        end
      end
      StSettle: if (cyc_last) state_d = StRun;
      StRun:    cnt_d = '0;  // untimed; hold the counter rather than let it wrap
      default:  state_d = StIdle;
    endcase

    // Abort from anywhere once the run request is withdrawn.
    if (state_q != StIdle && !command) state_d = StIdle;

    // The word index survives only the assert/gap alternation of the write phase.
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d != StWrAssert && state_d != StWrGap) idx_d = '0;
    end
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state register.
  always_comb begin
    cs_n_d     = 1'b1;
    r_n_w_d    = 1'b1;
    o_rest_n_d = 1'b1;
    oe_d       = 1'b0;
    data_o_d   = '0;
    busy_d     = (state_d != StIdle);
    cfg_done_d = 1'b0;
    unique case (state_d)
      StRstLo: o_rest_n_d = 1'b0;
      StWrAssert: begin
        cs_n_d   = 1'b0;
        oe_d     = 1'b1;
        data_o_d = words[idx_d];
      end
      StRun: begin
        cs_n_d     = 1'b0;
        r_n_w_d    = 1'b0;
        cfg_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // drdy_n synchroniser: sync_q[0] stage 1, [1] stage 2, [2] previous stage 2.
  assign sync_d    = {sync_q[1:0], adc.drdy_n};
  assign drdy_fall = sync_q[2] & ~sync_q[1];
  assign capture   = drdy_fall && (state_q == StRun);

  // Single-entry sample buffer with sticky overflow.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overflow_d   = overflow_q;
    if (capture) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = adc.adc_data_i;
        dout_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
    if (state_q == StIdle && state_d == StRstLo) overflow_d = 1'b0;
  end

  always_ff @(posedge mclk or negedge i_rest_n) begin
    if (!i_rest_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      sync_q       <= 3'b111;
      cs_n_q       <= 1'b1;
      r_n_w_q      <= 1'b1;
      o_rest_n_q   <= 1'b1;
      oe_q         <= 1'b0;
      data_o_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      cfg_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sync_q       <= sync_d;
      cs_n_q       <= cs_n_d;
      r_n_w_q      <= r_n_w_d;
      o_rest_n_q   <= o_rest_n_d;
      oe_q         <= oe_d;
      data_o_q     <= data_o_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      cfg_done_q   <= cfg_done_d;
    end
  end

  assign adc.cs_n        = cs_n_q;
  assign adc.r_n_w       = r_n_w_q;
  assign adc.o_rest_n    = o_rest_n_q;
  assign adc.adc_data_oe = oe_q;
  assign adc.adc_data_o  = data_o_q;
  assign dout            = dout_q;
  assign dout_valid      = dout_valid_q;
  assign overflow        = overflow_q;
  assign busy            = busy_q;
  assign cfg_done        = cfg_done_q;

endmodule

// File: tb/tb_adc_parallel_ctrl.sv
// Directed bench for adc_parallel_ctrl: default build plus a NUM_REGS=3 build
// with shortened timings.
module tb_adc_parallel_ctrl;
  localparam int unsigned DW = 16;

  logic          mclk = 1'b0;
  logic          i_rest_n;
  logic          command;
  logic [4*DW-1:0] cfg_table;
  logic [DW-1:0] dout;
  logic          dout_valid, dout_ready, overflow, busy, cfg_done;

  logic          command3;
  logic [6*DW-1:0] cfg_table3;
  logic [DW-1:0] dout3;
  logic          dout_valid3, overflow3, busy3, cfg_done3;

  int n_cmp = 0;
  int n_err = 0;
  int n;
  int nf;
  logic prev;

  logic [DW-1:0] exp_w  [4];
  logic [DW-1:0] exp_w3 [6];

  adc_parallel_ctrl_if #(.DATA_W(DW)) adc_if ();
  adc_parallel_ctrl_if #(.DATA_W(DW)) adc_if3 ();

  adc_parallel_ctrl #(.DATA_W(DW)) dut (
    .mclk       (mclk),
    .i_rest_n   (i_rest_n),
    .command    (command),
    .cfg_table  (cfg_table),
    .adc        (adc_if),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow),
    .busy       (busy),
    .cfg_done   (cfg_done)
  );

  adc_parallel_ctrl #(
    .DATA_W       (DW),
    .NUM_REGS     (3),
    .CS_LOW_CYC   (2),
    .CS_HIGH_CYC  (3),
    .RST_LOW_CYC  (1),
    .RST_HIGH_CYC (1),
    .SETTLE_CYC   (4)
  ) dut3 (
    .mclk       (mclk),
    .i_rest_n   (i_rest_n),
    .command    (command3),
    .cfg_table  (cfg_table3),
    .adc        (adc_if3),
    .dout       (dout3),
    .dout_valid (dout_valid3),
    .dout_ready (1'b1),
    .overflow   (overflow3),
    .busy       (busy3),
    .cfg_done   (cfg_done3)
  );

  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drdy_pulse(input logic [DW-1:0] val);
    adc_if.adc_data_i = val;
    adc_if.drdy_n = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_w  = '{16'h0000, 16'h0001, 16'h0022, 16'h0002};
    exp_w3 = '{16'h0010, 16'h00A0, 16'h0011, 16'h00B1, 16'h0012, 16'h00C2};
    cfg_table  = {16'h0022, 16'h0002, 16'h0000, 16'h0001};
    cfg_table3 = {16'h0012, 16'h00C2, 16'h0011, 16'h00B1, 16'h0010, 16'h00A0};
    i_rest_n = 1'b0;
    command  = 1'b0;
    command3 = 1'b0;
    dout_ready = 1'b0;
    adc_if.drdy_n = 1'b1;
    adc_if.adc_data_i = '0;
    adc_if3.drdy_n = 1'b1;
    adc_if3.adc_data_i = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_cs_n", adc_if.cs_n, 1);
    chk("rst_r_n_w", adc_if.r_n_w, 1);
    chk("rst_o_rest_n", adc_if.o_rest_n, 1);
    chk("rst_oe", adc_if.adc_data_oe, 0);
    chk("rst_data_o", adc_if.adc_data_o, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    i_rest_n = 1'b1;
    repeat (2) tick();
    chk("idle_without_cmd", busy, 0);

    // Configuration sequence
    command = 1'b1;
    tick();
    chk("rst_lo_enter", adc_if.o_rest_n, 0);
    chk("busy_after_start", busy, 1);
    n = 0;
    while (adc_if.o_rest_n === 1'b0 && n < 20) begin n++; tick(); end
    chk("rst_lo_len", n, 2);
    n = 0;
    while (adc_if.cs_n === 1'b1 && n < 50) begin n++; tick(); end
    chk("rst_hi_len", n, 3);
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("word%0d_data", w), adc_if.adc_data_o, exp_w[w]);
      chk($sformatf("word%0d_oe", w), adc_if.adc_data_oe, 1);
      chk($sformatf("word%0d_r_n_w", w), adc_if.r_n_w, 1);
      n = 0;
      while (adc_if.cs_n === 1'b0 && n < 50) begin n++; tick(); end
      chk($sformatf("word%0d_cs_low", w), n, 8);
      chk($sformatf("word%0d_gap_oe", w), adc_if.adc_data_oe, 0);
      chk($sformatf("word%0d_gap_data", w), adc_if.adc_data_o, 0);
      if (w < 3) begin
        n = 0;
        while (adc_if.cs_n === 1'b1 && n < 50) begin n++; tick(); end
        chk($sformatf("word%0d_cs_high", w), n, 8);
      end
    end
    n = 0;
    while (cfg_done !== 1'b1 && n < 100) begin n++; tick(); end
    chk("gap_plus_settle_len", n, 14);
    chk("run_cs_n", adc_if.cs_n, 0);
    chk("run_r_n_w", adc_if.r_n_w, 0);
    chk("run_oe", adc_if.adc_data_oe, 0);

    // Captures with consumer ready
    dout_ready = 1'b1;
    drdy_pulse(16'h1234);
    repeat (2) tick();
    chk("cap1_not_early", dout_valid, 0);
    tick();
    chk("cap1_valid", dout_valid, 1);
    chk("cap1_data", dout, 16'h1234);
    adc_if.drdy_n = 1'b1;
    tick();
    chk("cap1_accepted", dout_valid, 0);
    repeat (3) tick();
    drdy_pulse(16'hABCD);
    repeat (2) tick();
    chk("cap2_not_early", dout_valid, 0);
    tick();
    chk("cap2_valid", dout_valid, 1);
    chk("cap2_data", dout, 16'hABCD);
    adc_if.drdy_n = 1'b1;
    repeat (4) tick();
    chk("no_overflow", overflow, 0);

    // Overflow with consumer stalled
    dout_ready = 1'b0;
    drdy_pulse(16'h1111);
    repeat (3) tick();
    chk("hold_valid", dout_valid, 1);
    chk("hold_data", dout, 16'h1111);
    adc_if.drdy_n = 1'b1;
    repeat (4) tick();
    drdy_pulse(16'h2222);
    repeat (3) tick();
    chk("ovf_set", overflow, 1);
    chk("ovf_data_kept", dout, 16'h1111);
    chk("ovf_valid_kept", dout_valid, 1);
    adc_if.drdy_n = 1'b1;
    dout_ready = 1'b1;
    tick();
    chk("ovf_valid_clear", dout_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // Abort from RUN with a sample held
    repeat (3) tick();
    dout_ready = 1'b0;
    drdy_pulse(16'h5555);
    repeat (3) tick();
    adc_if.drdy_n = 1'b1;
    command = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_cs_n", adc_if.cs_n, 1);
    chk("abort_r_n_w", adc_if.r_n_w, 1);
    chk("abort_cfg_done", cfg_done, 0);
    chk("abort_dout_held", dout, 16'h5555);
    chk("abort_valid_held", dout_valid, 1);
    dout_ready = 1'b1;
    tick();
    chk("abort_valid_accept", dout_valid, 0);
    chk("ovf_before_restart", overflow, 1);

    // Restart, then abort during the third write word
    command = 1'b1;
    tick();
    chk("restart_rst_lo", adc_if.o_rest_n, 0);
    chk("restart_ovf_clear", overflow, 0);
    nf = 0;
    n = 0;
    prev = adc_if.cs_n;
    while (nf < 3 && n < 300) begin
      tick();
      n++;
      if (prev === 1'b1 && adc_if.cs_n === 1'b0) nf++;
      prev = adc_if.cs_n;
    end
    chk("third_word_reached", nf, 3);
    repeat (2) tick();
    chk("third_word_data", adc_if.adc_data_o, exp_w[2]);
    chk("third_word_oe", adc_if.adc_data_oe, 1);
    command = 1'b0;
    tick();
    chk("midwrite_abort_cs_n", adc_if.cs_n, 1);
    chk("midwrite_abort_oe", adc_if.adc_data_oe, 0);
    chk("midwrite_abort_data", adc_if.adc_data_o, 0);
    chk("midwrite_abort_busy", busy, 0);
    tick();
    chk("idle_stays", busy, 0);
    command = 1'b1;
    tick();
    chk("restart2_rst_lo", adc_if.o_rest_n, 0);
    n = 0;
    while (cfg_done !== 1'b1 && n < 300) begin n++; tick(); end
    chk("restart2_done", cfg_done, 1);

    // Asynchronous reset in RUN with a sample held
    dout_ready = 1'b0;
    drdy_pulse(16'h7777);
    repeat (3) tick();
    adc_if.drdy_n = 1'b1;
    chk("pre_reset_valid", dout_valid, 1);
    #3;
    i_rest_n = 1'b0;
    #1;
    chk("areset_cs_n", adc_if.cs_n, 1);
    chk("areset_r_n_w", adc_if.r_n_w, 1);
    chk("areset_o_rest_n", adc_if.o_rest_n, 1);
    chk("areset_oe", adc_if.adc_data_oe, 0);
    chk("areset_dout", dout, 0);
    chk("areset_valid", dout_valid, 0);
    chk("areset_busy", busy, 0);
    chk("areset_cfg_done", cfg_done, 0);
    command = 1'b0;
    tick();
    i_rest_n = 1'b1;
    repeat (2) tick();
    chk("post_reset_idle", busy, 0);

    // NUM_REGS=3 build: six words in index order
    command3 = 1'b1;
    for (int w = 0; w < 6; w++) begin
      n = 0;
      while (adc_if3.cs_n === 1'b1 && n < 100) begin n++; tick(); end
      chk($sformatf("n3_word%0d_data", w), adc_if3.adc_data_o, exp_w3[w]);
      n = 0;
      while (adc_if3.cs_n === 1'b0 && n < 100) begin n++; tick(); end
      chk($sformatf("n3_word%0d_cs_low", w), n, 2);
    end
    n = 0;
    while (cfg_done3 !== 1'b1 && n < 100) begin n++; tick(); end
    chk("n3_gap_plus_settle", n, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
